// File: rtl/counter_pkg.sv
// Shared types for the counter slice: count width, count type and JK command encoding.
package counter_pkg;

    localparam int unsigned COUNT_W = 3;

    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_cmd_t;

endpackage

// File: rtl/posedge_jk_flipflop_arst.sv
// Rising-edge JK flip-flop with asynchronous active-high reset to 0.
module posedge_jk_flipflop_arst
    import counter_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic not_Q
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q <= 1'b0;
        end else begin
            case (jk_cmd_t'({J, K}))
                JK_CLEAR:  Q <= 1'b0;
                JK_SET:    Q <= 1'b1;
                JK_TOGGLE: Q <= ~Q;
                default:   Q <= Q;
            endcase
        end
    end

    assign not_Q = ~Q;

endmodule

// File: rtl/posedge_3bit_up_counter.sv
// Synchronous 3-bit modulo-MODULUS up counter built from JK flip-flops with load.
// Optional sticky overflow output OVF when COUNTER_OVERFLOW_FLAG_EN is defined.
module posedge_3bit_up_counter
    import counter_pkg::*;
#(
    parameter int MODULUS = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [2:0]   D,
    output logic         Q0,
    output logic         Q1,
    output logic         Q2,
    output logic         TC
`ifdef COUNTER_OVERFLOW_FLAG_EN
    ,
    output logic         OVF
`endif
);

    if (MODULUS < 2 || MODULUS > 8) begin : g_bad_modulus
        $error("posedge_3bit_up_counter: MODULUS must be in 2..8");
    end

    localparam count_t MAX_CNT = count_t'(MODULUS - 1);

    count_t q_v;
    count_t q_n;
    count_t nxt;
    count_t j_v;
    count_t k_v;
    logic   at_max;
    logic   wrap;
    logic   carry;

    always_comb begin
        at_max = (q_v == MAX_CNT);
        wrap   = EN & ~LOAD & at_max;
        nxt    = '0;
        if (LOAD && (D <= MAX_CNT)) begin
            nxt = D;
        end
        j_v   = '0;
        k_v   = '0;
        carry = EN;
        // Load/wrap steer each stage straight to its target bit; otherwise the
        // classic ripple-carry toggle term drives J=K.
        for (int unsigned i = 0; i < COUNT_W; i++) begin
            if (LOAD || wrap) begin
                j_v[i] = nxt[i] & q_n[i];
                k_v[i] = ~nxt[i] & q_v[i];
            end else begin
                j_v[i] = carry;
                k_v[i] = carry;
            end
            carry = carry & q_v[i];
        end
    end

    for (genvar i = 0; i < COUNT_W; i++) begin : g_stage
        posedge_jk_flipflop_arst u_ff (
            .CLK   (CLK),
            .RST   (RST),
            .J     (j_v[i]),
            .K     (k_v[i]),
            .Q     (q_v[i]),
            .not_Q (q_n[i])
        );
    end

    assign Q0 = q_v[0];
    assign Q1 = q_v[1];
    assign Q2 = q_v[2];
    assign TC = EN & ~LOAD & ~RST & at_max;

`ifdef COUNTER_OVERFLOW_FLAG_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (LOAD) begin
            OVF <= 1'b0;
        end else if (wrap) begin
            OVF <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_posedge_3bit_up_counter.sv
// Randomized self-checking bench: MODULUS=8 and MODULUS=5 counters against an arithmetic model.
module tb_posedge_3bit_up_counter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic       LOAD;
    logic [2:0] D;
    logic       a_q0, a_q1, a_q2, a_tc;
    logic       b_q0, b_q1, b_q2, b_tc;
`ifdef COUNTER_OVERFLOW_FLAG_EN
    logic       a_ovf, b_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int mods[2] = '{8, 5};
    int m_cnt[2];
    int m_ovf[2];

    always #5 CLK = ~CLK;

    posedge_3bit_up_counter #(.MODULUS(8)) dut_a (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .LOAD (LOAD),
        .D    (D),
        .Q0   (a_q0),
        .Q1   (a_q1),
        .Q2   (a_q2),
        .TC   (a_tc)
`ifdef COUNTER_OVERFLOW_FLAG_EN
        ,
        .OVF  (a_ovf)
`endif
    );

    posedge_3bit_up_counter #(.MODULUS(5)) dut_b (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .LOAD (LOAD),
        .D    (D),
        .Q0   (b_q0),
        .Q1   (b_q1),
        .Q2   (b_q2),
        .TC   (b_tc)
`ifdef COUNTER_OVERFLOW_FLAG_EN
        ,
        .OVF  (b_ovf)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_q(input int k);
        return (k == 0) ? {29'd0, a_q2, a_q1, a_q0} : {29'd0, b_q2, b_q1, b_q0};
    endfunction

    function automatic logic [31:0] dut_tc(input int k);
        return (k == 0) ? {31'd0, a_tc} : {31'd0, b_tc};
    endfunction

    task automatic check_q(input string phase);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_q_m%0d", phase, mods[k]), dut_q(k), m_cnt[k]);
`ifdef COUNTER_OVERFLOW_FLAG_EN
            check_eq($sformatf("%s_ovf_m%0d", phase, mods[k]),
                     (k == 0) ? {31'd0, a_ovf} : {31'd0, b_ovf}, m_ovf[k]);
`endif
        end
    endtask

    task automatic check_tc(input string phase);
        for (int k = 0; k < 2; k++) begin
            int exp;
            exp = (EN && !LOAD && !RST && m_cnt[k] == mods[k] - 1) ? 1 : 0;
            check_eq($sformatf("%s_tc_m%0d", phase, mods[k]), dut_tc(k), exp);
        end
    endtask

    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            if (LOAD) begin
                m_ovf[k] = 0;
                m_cnt[k] = (int'(D) < mods[k]) ? int'(D) : 0;
            end else if (EN) begin
                if (m_cnt[k] == mods[k] - 1) m_ovf[k] = 1;
                m_cnt[k] = (m_cnt[k] + 1) % mods[k];
            end
        end
    endfunction

    task automatic cycle(input string phase, input logic en, input logic load, input logic [2:0] d);
        @(negedge CLK);
        EN = en;
        LOAD = load;
        D = d;
        #1 check_tc(phase);
        @(posedge CLK);
        model_edge();
        #1 check_q(phase);
    endtask

    // Reset asserted mid-cycle, held across one edge with LOAD/EN active, then released.
    task automatic reset_pulse(input string phase);
        @(negedge CLK);
        #2 RST = 1'b1;
        EN = 1'b1;
        LOAD = 1'b1;
        D = 3'd3;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
        #1 check_q({phase, "_async"});
        check_tc({phase, "_async"});
        @(posedge CLK);
        #1 check_q({phase, "_held"});
        @(negedge CLK);
        RST = 1'b0;
        EN = 1'b0;
        LOAD = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        EN = 1'b0;
        LOAD = 1'b0;
        D = 3'd0;
        m_cnt = '{0, 0};
        m_ovf = '{0, 0};
        #12 check_q("reset");
        check_tc("reset");
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 9; i++) cycle("free", 1'b1, 1'b0, 3'd0);

        cycle("load6", 1'b0, 1'b1, 3'd6);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b0, 3'd0);

        cycle("load7", 1'b0, 1'b1, 3'd7);
        cycle("load_en", 1'b1, 1'b1, 3'd2);

        cycle("to5", 1'b0, 1'b1, 3'd5);
        reset_pulse("midrst");

        cycle("to7", 1'b0, 1'b1, 3'd7);
        for (int i = 0; i < 4; i++) cycle("ovf", 1'b1, 1'b0, 3'd0);
        cycle("ovf_clr", 1'b0, 1'b1, 3'd3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset_pulse("rnd_rst");
            end else begin
                cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                      3'($urandom_range(0, 7)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
